// File: rtl/gpio_expander_wb_if.sv
// Wishbone classic slave bus bundle for the GPIO expander.
// The bus master drives the strobe, address and write data; the expander returns ack and read data.
interface gpio_expander_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/gpio_expander_wb.sv
// Wishbone GPIO expander: atomic output ops, output enables, synchronised inputs,
// sticky edge interrupts and a heartbeat square wave.
module gpio_expander_wb #(
    parameter int unsigned NPINS       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HB_DIV      = 12500000,
    parameter logic [31:0] VERSION     = 32'h0002_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    gpio_expander_wb_if.slave  wbs,
    input  logic [NPINS-1:0]   gpi,
    output logic [NPINS-1:0]   gpo,
    output logic [NPINS-1:0]   gpio_oeb,
    output logic               irq_o,
    output logic               hb_o
);
    localparam logic [3:0]  REG_DATA_OUT = 4'h0;
    localparam logic [3:0]  REG_OUT_SET  = 4'h1;
    localparam logic [3:0]  REG_OUT_CLR  = 4'h2;
    localparam logic [3:0]  REG_OUT_TGL  = 4'h3;
    localparam logic [3:0]  REG_OE       = 4'h4;
    localparam logic [3:0]  REG_DATA_IN  = 4'h5;
    localparam logic [3:0]  REG_RISE_EN  = 4'h6;
    localparam logic [3:0]  REG_FALL_EN  = 4'h7;
    localparam logic [3:0]  REG_IRQ_STAT = 4'h8;
    localparam logic [3:0]  REG_ID       = 4'h9;
    localparam logic [31:0] HB_LAST      = 32'(HB_DIV - 32'd1);

    function automatic logic [31:0] widen(input logic [NPINS-1:0] x);
        logic [31:0] w;
        w           = 32'd0;
        w[NPINS-1:0] = x;
        return w;
    endfunction

    function automatic logic [NPINS-1:0] narrow(input logic [31:0] x);
        return x[NPINS-1:0];
    endfunction

    logic [NPINS-1:0]                  data_out_q, data_out_d;
    logic [NPINS-1:0]                  oe_q, oe_d;
    logic [NPINS-1:0]                  rise_en_q, rise_en_d;
    logic [NPINS-1:0]                  fall_en_q, fall_en_d;
    logic [NPINS-1:0]                  irq_status_q, irq_status_d;
    logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
    logic [NPINS-1:0]                  prev_in_q, prev_in_d;
    logic [31:0]                       hb_cnt_q, hb_cnt_d;
    logic                              hb_q, hb_d;
    logic                              ack_q, ack_d;
    logic [31:0]                       dat_o_q, dat_o_d;

    logic             acc_s, wr_s;
    logic [3:0]       reg_idx_s;
    logic [31:0]      byte_mask_s, wbits_s, rdata_s;
    logic [NPINS-1:0] sync_in_s, rise_s, fall_s, irq_w1c_s;
    logic             unused_adr_s;

    assign unused_adr_s = ^{wbs.wbs_adr_i[31:6], wbs.wbs_adr_i[1:0]};

    // Bus decode, register next-state, input edge detection and heartbeat.
    always_comb begin
        acc_s       = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
        wr_s        = acc_s & wbs.wbs_we_i;
        reg_idx_s   = wbs.wbs_adr_i[5:2];
        byte_mask_s = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                       {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
        // Unselected bytes behave as zero data for the atomic and W1C registers.
        wbits_s     = wbs.wbs_dat_i & byte_mask_s;

        sync_in_s = sync_q[SYNC_STAGES-1];
        rise_s    = sync_in_s & ~prev_in_q;
        fall_s    = ~sync_in_s & prev_in_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], gpi};
        prev_in_d = sync_in_s;

        data_out_d = data_out_q;
        oe_d       = oe_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_w1c_s  = '0;
        if (wr_s) begin
            case (reg_idx_s)
                REG_DATA_OUT: data_out_d = narrow((widen(data_out_q) & ~byte_mask_s) | wbits_s);
                REG_OUT_SET:  data_out_d = data_out_q | narrow(wbits_s);
                REG_OUT_CLR:  data_out_d = data_out_q & ~narrow(wbits_s);
                REG_OUT_TGL:  data_out_d = data_out_q ^ narrow(wbits_s);
                REG_OE:       oe_d       = narrow((widen(oe_q) & ~byte_mask_s) | wbits_s);
                REG_RISE_EN:  rise_en_d  = narrow((widen(rise_en_q) & ~byte_mask_s) | wbits_s);
                REG_FALL_EN:  fall_en_d  = narrow((widen(fall_en_q) & ~byte_mask_s) | wbits_s);
                REG_IRQ_STAT: irq_w1c_s  = narrow(wbits_s);
                default:      irq_w1c_s  = '0;
            endcase
        end else begin
            irq_w1c_s = '0;
        end
        // A new enabled edge wins over a same-cycle clear of that bit.
        irq_status_d = (irq_status_q & ~irq_w1c_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);

        case (reg_idx_s)
            REG_DATA_OUT: rdata_s = widen(data_out_q);
            REG_OE:       rdata_s = widen(oe_q);
            REG_DATA_IN:  rdata_s = widen(sync_in_s);
            REG_RISE_EN:  rdata_s = widen(rise_en_q);
            REG_FALL_EN:  rdata_s = widen(fall_en_q);
            REG_IRQ_STAT: rdata_s = widen(irq_status_q);
            REG_ID:       rdata_s = VERSION;
            default:      rdata_s = 32'd0;
        endcase
        ack_d   = acc_s;
        dat_o_d = acc_s ? rdata_s : 32'd0;

        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = 32'd0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + 32'd1;
            hb_d     = hb_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            data_out_q   <= '0;
            oe_q         <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            sync_q       <= '0;
            prev_in_q    <= '0;
            hb_cnt_q     <= 32'd0;
            hb_q         <= 1'b0;
            ack_q        <= 1'b0;
            dat_o_q      <= 32'd0;
        end else begin
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            sync_q       <= sync_d;
            prev_in_q    <= prev_in_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_q         <= hb_d;
            ack_q        <= ack_d;
            dat_o_q      <= dat_o_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_o_q;
    assign gpo           = data_out_q;
    assign gpio_oeb      = ~oe_q;
    assign irq_o         = |irq_status_q;
    assign hb_o          = hb_q;
endmodule

// File: tb/tb_gpio_expander_wb.sv
// Self-checking bench: a 32-pin instance (HB_DIV=4) and an 8-pin instance on one clock.
// Read expectations go through a scoreboard queue and are popped when the ack arrives.
module tb_gpio_expander_wb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpi_a;
    logic [7:0]  gpi_b;
    logic [31:0] gpo_a, oeb_a;
    logic [7:0]  gpo_b, oeb_b;
    logic        irq_a, hb_a, irq_b, hb_b;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    gpio_expander_wb_if bus_a();
    gpio_expander_wb_if bus_b();

    gpio_expander_wb #(.NPINS(32), .SYNC_STAGES(2), .HB_DIV(4)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus_a.slave),
        .gpi(gpi_a), .gpo(gpo_a), .gpio_oeb(oeb_a), .irq_o(irq_a), .hb_o(hb_a));

    gpio_expander_wb #(.NPINS(8)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus_b.slave),
        .gpi(gpi_b), .gpo(gpo_b), .gpio_oeb(oeb_b), .irq_o(irq_b), .hb_o(hb_b));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input int dev, input logic stb, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (dev == 0) begin
            bus_a.wbs_stb_i = stb; bus_a.wbs_cyc_i = stb; bus_a.wbs_we_i = we;
            bus_a.wbs_adr_i = adr; bus_a.wbs_dat_i = dat; bus_a.wbs_sel_i = sel;
        end else begin
            bus_b.wbs_stb_i = stb; bus_b.wbs_cyc_i = stb; bus_b.wbs_we_i = we;
            bus_b.wbs_adr_i = adr; bus_b.wbs_dat_i = dat; bus_b.wbs_sel_i = sel;
        end
    endtask

    // One bus access starting at posedge+1; checks ack latency/width and pops read expectations.
    task automatic bus_xfer(input int dev, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input string name);
        int          waited;
        logic        got;
        logic [31:0] rd, expv;
        drive_bus(dev, 1'b1, we, adr, dat, sel);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 8) begin
            tick(1);
            waited++;
            got = (dev == 0) ? bus_a.wbs_ack_o : bus_b.wbs_ack_o;
        end
        rd = (dev == 0) ? bus_a.wbs_dat_o : bus_b.wbs_dat_o;
        drive_bus(dev, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        n_vec++;
        if (!got || waited != 1) begin
            n_err++;
            $display("FAIL %s ack_latency: got %0d cycles (acked=%b), expected 1", name, waited, got);
        end
        if (!we) begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_vec++;
            if (rd !== expv) begin
                n_err++;
                $display("FAIL %s read: got %h, expected %h", name, rd, expv);
            end
        end
        tick(1);
        got = (dev == 0) ? bus_a.wbs_ack_o : bus_b.wbs_ack_o;
        rd  = (dev == 0) ? bus_a.wbs_dat_o : bus_b.wbs_dat_o;
        n_vec++;
        if (got !== 1'b0 || rd !== 32'd0) begin
            n_err++;
            $display("FAIL %s ack_single: ack=%b dat=%h, expected ack=0 dat=0", name, got, rd);
        end
    endtask

    task automatic wr(input int dev, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input string name);
        bus_xfer(dev, 1'b1, adr, dat, sel, name);
    endtask

    task automatic rd(input int dev, input logic [31:0] adr, input logic [31:0] expv, input string name);
        exp_q.push_back(expv);
        bus_xfer(dev, 1'b0, adr, 32'd0, 4'hF, name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        gpi_a = 32'hFFFF_FFFF;
        gpi_b = 8'hFF;
        drive_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_bus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick(3);
        n_vec++;
        if (gpo_a !== 32'd0 || oeb_a !== 32'hFFFF_FFFF || irq_a !== 1'b0 || hb_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outs: gpo=%h oeb=%h irq=%b hb=%b, expected 0/ffffffff/0/0",
                     gpo_a, oeb_a, irq_a, hb_a);
        end
        n_vec++;
        if (bus_a.wbs_ack_o !== 1'b0 || bus_a.wbs_dat_o !== 32'd0 || gpo_b !== 8'd0 || oeb_b !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_bus: ack=%b dat=%h gpo_b=%h oeb_b=%h, expected 0/0/00/ff",
                     bus_a.wbs_ack_o, bus_a.wbs_dat_o, gpo_b, oeb_b);
        end
        rst_n = 1'b1;
        tick(5);
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_stale_irq: irq=%b, expected 0", irq_a);
        end
        rd(0, 32'h24, 32'h0002_0000, "id");
        rd(0, 32'h14, 32'hFFFF_FFFF, "data_in_ones");
        gpi_a = 32'd0;
        gpi_b = 8'd0;
        tick(4);
        rd(0, 32'h20, 32'd0, "irq_clean");
    endtask

    task automatic test_atomic;
        wr(0, 32'h00, 32'h0000_00F0, 4'hF, "w_dout");
        wr(0, 32'h04, 32'h0000_000F, 4'hF, "w_set");
        wr(0, 32'h08, 32'h0000_0030, 4'hF, "w_clr");
        wr(0, 32'h0C, 32'h8000_0001, 4'hF, "w_tgl");
        n_vec++;
        if (gpo_a !== 32'h8000_00CE) begin
            n_err++;
            $display("FAIL atomic_gpo: got %h, expected 800000ce", gpo_a);
        end
        rd(0, 32'h00, 32'h8000_00CE, "dout_rb");
        rd(0, 32'h04, 32'd0, "set_reads0");
        wr(0, 32'h00, 32'd0, 4'hF, "w_dout0");
        wr(0, 32'h04, 32'hFFFF_FFFF, 4'b0001, "w_set_sel");
        n_vec++;
        if (gpo_a !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL set_bytesel: got %h, expected 000000ff", gpo_a);
        end
        wr(0, 32'h00, 32'hAAAA_AAAA, 4'b0010, "w_dout_sel");
        rd(0, 32'h00, 32'h0000_AAFF, "dout_bytesel");
        wr(0, 32'h10, 32'h0000_FFFF, 4'hF, "w_oe");
        n_vec++;
        if (oeb_a !== 32'hFFFF_0000) begin
            n_err++;
            $display("FAIL oe_oeb: got %h, expected ffff0000", oeb_a);
        end
    endtask

    task automatic test_edge_irq;
        wr(0, 32'h18, 32'h1, 4'hF, "w_rise_en");
        wr(0, 32'h1C, 32'h2, 4'hF, "w_fall_en");
        gpi_a = 32'h3;
        tick(2);
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL irq_early: irq=%b, expected 0", irq_a);
        end
        tick(1);
        n_vec++;
        if (irq_a !== 1'b1) begin
            n_err++;
            $display("FAIL irq_latency: irq=%b, expected 1", irq_a);
        end
        rd(0, 32'h14, 32'h3, "data_in");
        gpi_a = 32'h0;
        tick(6);
        rd(0, 32'h20, 32'h3, "status_3");
        wr(0, 32'h20, 32'h1, 4'hF, "w1c_1");
        rd(0, 32'h20, 32'h2, "status_2");
        n_vec++;
        if (irq_a !== 1'b1) begin
            n_err++;
            $display("FAIL irq_still: irq=%b, expected 1", irq_a);
        end
        wr(0, 32'h20, 32'h2, 4'hF, "w1c_2");
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL irq_cleared: irq=%b, expected 0", irq_a);
        end
    endtask

    task automatic test_collision;
        gpi_a = 32'h1;
        tick(5);
        gpi_a = 32'h0;
        tick(5);
        rd(0, 32'h20, 32'h1, "coll_pre");
        gpi_a = 32'h1;
        tick(2);
        wr(0, 32'h20, 32'h1, 4'hF, "coll_w1c");
        rd(0, 32'h20, 32'h1, "coll_kept");
        gpi_a = 32'h0;
        tick(4);
    endtask

    task automatic test_narrow;
        wr(1, 32'h00, 32'hFFFF_FFFF, 4'hF, "b_w_dout");
        rd(1, 32'h00, 32'h0000_00FF, "b_dout_rb");
        n_vec++;
        if (gpo_b !== 8'hFF) begin
            n_err++;
            $display("FAIL b_gpo: got %h, expected ff", gpo_b);
        end
        wr(1, 32'h3C, 32'hFFFF_FFFF, 4'hF, "b_w_unmapped");
        rd(1, 32'h3C, 32'd0, "b_unmapped");
        rd(1, 32'h24, 32'h0002_0000, "b_id");
    endtask

    task automatic test_heartbeat;
        int   m_cnt;
        logic m_hb;
        for (int pass = 0; pass < 2; pass++) begin
            rst_n = 1'b0;
            tick(1);
            n_vec++;
            if (hb_a !== 1'b0) begin
                n_err++;
                $display("FAIL hb_reset: hb=%b, expected 0", hb_a);
            end
            rst_n = 1'b1;
            m_cnt = 0;
            m_hb  = 1'b0;
            for (int i = 0; i < 14; i++) begin
                tick(1);
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    m_hb  = ~m_hb;
                end else begin
                    m_cnt++;
                end
                n_vec++;
                if (hb_a !== m_hb) begin
                    n_err++;
                    $display("FAIL hb_cycle%0d: hb=%b, expected %b", i, hb_a, m_hb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_atomic();
        test_edge_irq();
        test_collision();
        test_narrow();
        test_heartbeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
